// File: rtl/bias_add_stage.sv
// Bias-add stage: adds a per-neuron signed bias (8 lanes per ROM word) to each accumulator
// value, saturates to OUT_WIDTH. Define BIAS_ADD_RELU_EN to clamp negative results to zero.
module bias_add_stage #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 128,
   parameter int NUM_BIAS   = 122,
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 16,
   parameter int IDX_WIDTH  = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_q,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ACC_WIDTH-1:0]  in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic [IDX_WIDTH-1:0]  out_idx,
   output logic                  out_last
);
   localparam int LANES     = 8;
   localparam int LANE_BITS = 3;
   localparam int LANE_W    = DATA_WIDTH / LANES;

   localparam logic signed [ACC_WIDTH:0] SAT_MAX =
      {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] SAT_MIN =
      {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {FETCH, LOAD, RUN} state_t;

   state_t                 r_state;
   logic [IDX_WIDTH-1:0]   r_n;
   logic [DATA_WIDTH-1:0]  r_bias;
   logic                   r_out_valid;
   logic [OUT_WIDTH-1:0]   r_out_data;
   logic [IDX_WIDTH-1:0]   r_out_idx;
   logic                   r_out_last;

   logic [LANE_W-1:0]      w_lane [LANES];
   logic [LANE_W-1:0]      w_bias;
   logic signed [ACC_WIDTH:0] w_sum;
   logic [OUT_WIDTH-1:0]   w_sat;
   logic [OUT_WIDTH-1:0]   w_res;
   logic                   w_in_ready;
   logic                   w_in_hs;
   logic                   w_last;
   logic                   w_lane_end;

   // Lane 0 sits in the most significant slice of the word.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane[gi] = r_bias[DATA_WIDTH-1-LANE_W*gi -: LANE_W];
   end

   assign w_bias     = w_lane[r_n[LANE_BITS-1:0]];
   assign w_sum      = {in_data[ACC_WIDTH-1], in_data}
                     + {{(ACC_WIDTH+1-LANE_W){w_bias[LANE_W-1]}}, w_bias};
   assign w_in_ready = (r_state == RUN) && (!r_out_valid || out_ready);
   assign w_in_hs    = in_valid && w_in_ready;
   assign w_last     = in_last || (r_n == IDX_WIDTH'(NUM_BIAS-1));
   assign w_lane_end = &r_n[LANE_BITS-1:0];

   always_comb begin
      if (w_sum > SAT_MAX)
         w_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else if (w_sum < SAT_MIN)
         w_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else
         w_sat = w_sum[OUT_WIDTH-1:0];
   end

`ifdef BIAS_ADD_RELU_EN
   assign w_res = w_sat[OUT_WIDTH-1] ? '0 : w_sat;
`else
   assign w_res = w_sat;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= FETCH;
         r_n         <= '0;
         r_bias      <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_out_last  <= 1'b0;
      end else begin
         case (r_state)
            FETCH: r_state <= LOAD;
            LOAD: begin
               r_bias  <= rom_q;
               r_state <= RUN;
            end
            RUN: begin
               if (w_in_hs) begin
                  // A frame end (early or natural) always restarts from word 0.
                  if (w_last) begin
                     r_n     <= '0;
                     r_state <= FETCH;
                  end else begin
                     r_n <= r_n + 1'b1;
                     if (w_lane_end)
                        r_state <= FETCH;
                  end
               end
            end
            default: r_state <= FETCH;
         endcase

         if (w_in_hs) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
            r_out_idx   <= r_n;
            r_out_last  <= w_last;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign rom_addr  = ADDR_WIDTH'(r_n >> LANE_BITS);
   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_idx   = r_out_idx;
   assign out_last  = r_out_last;

endmodule

// File: tb/tb_bias_add_stage.sv
// Randomized self-checking bench for bias_add_stage: ROM model, queue-based reference of
// expected results, per-cycle compare process, plus literal pins of known cases.
module tb_bias_add_stage;
   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    rom_addr;
   logic [127:0]  rom_q;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_data;
   logic [6:0]    out_idx;
   logic          out_last;

   always #5 clk = ~clk;

   bias_add_stage dut (
      .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_q(rom_q),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last)
   );

`ifdef BIAS_ADD_RELU_EN
   localparam logic [15:0] NEG_SAT_EXP = 16'h0000;
   localparam logic [15:0] IDX121_EXP  = 16'h0000;
`else
   localparam logic [15:0] NEG_SAT_EXP = 16'h8000;
   localparam logic [15:0] IDX121_EXP  = 16'hF5C1;
`endif

   logic [127:0] rom_mem [16];
   always @(posedge clk) rom_q <= rom_mem[rom_addr];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [15:0] d;
      logic [6:0]  idx;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   mdl_n = 0;
   int   n_in_hs = 0, n_out_hs = 0, n_dropped = 0;
   logic [15:0] out_log [128];
   logic        last_log [128];

   // Reference: bias lane n%8 of word n/8, signed add, clamp, optional ReLU.
   function automatic logic [15:0] model_out(input int n, input logic [31:0] data);
      logic [127:0] w;
      logic [15:0]  b;
      longint       sd, sb, s;
      w  = rom_mem[n/8];
      b  = w[127-16*(n%8) -: 16];
      sd = $signed(data);
      sb = $signed(b);
      s  = sd + sb;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`ifdef BIAS_ADD_RELU_EN
      if (s < 0) s = 0;
`endif
      return s[15:0];
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         n_dropped += exp_q.size();
         exp_q.delete();
         mdl_n = 0;
      end else begin
         check("rom_addr", rom_addr, mdl_n / 8);
         check("out_valid", out_valid, exp_q.size() > 0);
         if (exp_q.size() > 0) begin
            check("out_data", out_data, exp_q[0].d);
            check("out_idx", out_idx, exp_q[0].idx);
            check("out_last", out_last, exp_q[0].last);
         end
         if (out_valid && !out_ready)
            check("in_ready_stall", in_ready, 0);
         if (out_valid && out_ready) begin
            out_log[out_idx]  = out_data;
            last_log[out_idx] = out_last;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            n_out_hs++;
         end
         if (in_valid && in_ready) begin
            e.d    = model_out(mdl_n, in_data);
            e.idx  = 7'(mdl_n);
            e.last = in_last || (mdl_n == 121);
            exp_q.push_back(e);
            mdl_n  = e.last ? 0 : mdl_n + 1;
            n_in_hs++;
         end
      end
   end

   // out_ready: 0 = always, 1 = random, 2 = one 5-cycle stall at idx 9, 3 = never
   int or_mode = 0;
   int stall_left = 0;
   bit stall_done = 1'b0;
   always @(posedge clk) begin
      #1;
      case (or_mode)
         0: out_ready = 1'b1;
         1: out_ready = ($urandom % 4) != 0;
         2: begin
            if (stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end else if (!stall_done && out_valid && out_idx == 7'd9) begin
               out_ready  = 1'b0;
               stall_left = 4;
               stall_done = 1'b1;
            end else begin
               out_ready = 1'b1;
            end
         end
         default: out_ready = 1'b0;
      endcase
   end

   int cyc = 0;

   task automatic push_one(input logic [31:0] d, input logic last, input int idle_pct);
      int waited = 0;
      @(posedge clk); #1;
      while (idle_pct > 0 && int'($urandom % 100) < idle_pct) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      forever begin
         @(negedge clk);
         cyc++;
         if (in_ready) break;
         waited++;
         if (waited > 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: got no in_ready expected accept within 300 clk");
            #1 in_valid = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   function automatic logic [31:0] rand_data();
      int v;
      case ($urandom % 4)
         0: v = int'($urandom_range(6000)) - 3000;
         1: v = int'($urandom_range(50000, 30000));
         2: v = -int'($urandom_range(50000, 30000));
         default: v = int'($urandom);
      endcase
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected end before 1000000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] neg;
      int base;
      rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      for (int w = 0; w < 16; w++)
         rom_mem[w] = {$urandom, $urandom, $urandom, $urandom};
      rom_mem[0][127:112] = 16'hF690;
      rom_mem[15][127:96] = 32'h0418F5C1;

      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_out_data", out_data, 0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      check("fetch_rom_addr", rom_addr, 0);
      check("fetch_in_ready", in_ready, 0);
      @(negedge clk);
      check("load_in_ready", in_ready, 0);
      @(negedge clk);
      check("run_in_ready_cycle3", in_ready, 1);
      check("idle_out_valid", out_valid, 0);

      // Word 0 lane 0 bias 0xF690 plus 1000.
      push_one(32'd1000, 1'b1, 0);
      idle();
      @(negedge clk);
      check("pin_basic_valid", out_valid, 1);
      check("pin_basic_data", out_data, 16'hFA78);
      check("pin_basic_idx", out_idx, 0);

      push_one(32'd40000, 1'b1, 0);
      idle();
      @(negedge clk);
      check("pin_sat_pos", out_data, 16'h7FFF);
      neg = -40000;
      push_one(neg, 1'b1, 0);
      idle();
      @(negedge clk);
      check("pin_sat_neg", out_data, NEG_SAT_EXP);

      // Full frame, no backpressure; idx 120/121 get zero input to expose the raw biases.
      push_one(rand_data(), 1'b1, 0);
      for (int i = 0; i < 128; i++) begin
         out_log[i]  = 16'hDEAD;
         last_log[i] = 1'b0;
      end
      cyc = 0;
      for (int i = 0; i < 122; i++)
         push_one((i >= 120) ? 32'd0 : rand_data(), 1'b0, 0);
      check("frame_cycles", cyc, 154);
      idle();
      @(negedge clk);
      check("wrap_rom_addr", rom_addr, 0);
      @(negedge clk);
      check("pin_idx120", out_log[120], 16'h0418);
      check("pin_idx121", out_log[121], IDX121_EXP);
      check("pin_last120", last_log[120], 0);
      check("pin_last121", last_log[121], 1);

      // Backpressure stall at idx 9.
      or_mode = 2;
      stall_done = 1'b0;
      base = n_out_hs;
      for (int i = 0; i < 122; i++)
         push_one(rand_data(), 1'b0, 0);
      idle();
      repeat (3) @(negedge clk);
      check("stall_hit", stall_done, 1);
      check("stall_frame_count", n_out_hs - base, 122);
      or_mode = 0;

      // Early in_last at n=3, then a fresh frame must start at word 0 lane 0.
      for (int i = 0; i < 4; i++)
         push_one(rand_data(), i == 3, 0);
      push_one(32'd1000, 1'b1, 0);
      idle();
      @(negedge clk);
      check("early_last_data", out_data, 16'hFA78);
      check("early_last_idx", out_idx, 0);

      // Random traffic with random backpressure and occasional early frame ends.
      or_mode = 1;
      for (int i = 0; i < 600; i++)
         push_one(rand_data(), ($urandom % 40) == 0, 25);
      idle();
      or_mode = 0;
      repeat (5) @(negedge clk);

      // Mid-frame reset with a held result.
      or_mode = 3;
      @(posedge clk);
      push_one(32'd1234, 1'b0, 0);
      idle();
      repeat (3) @(negedge clk);
      check("held_before_rst", out_valid, 1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 0);
      check("arst_rom_addr", rom_addr, 0);
      check("arst_out_data", out_data, 0);
      check("arst_out_idx", out_idx, 0);
      check("arst_out_last", out_last, 0);
      or_mode = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_rom_addr", rom_addr, 0);
      check("post_rst_in_ready", in_ready, 0);
      push_one(32'd1000, 1'b1, 0);
      idle();
      @(negedge clk);
      check("post_rst_data", out_data, 16'hFA78);
      check("post_rst_idx", out_idx, 0);

      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      check("io_balance", n_out_hs + n_dropped, n_in_hs);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
